// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the pc_sequencer instruction-pointer stage:
// FSM state encodings, address/target/NOP-count widths and the default reset vector.
package pc_sequencer_pkg;

    localparam int IP_W      = 16;
    localparam int TARGET_W  = 8;
    localparam int NOP_CNT_W = 24;

    localparam logic [IP_W-1:0] DEFAULT_RESET_VECTOR = 16'd0;

    typedef enum logic [0:0] {
        STATE_RUN  = 1'b0,
        STATE_WAIT = 1'b1
    } state_e;

    function automatic logic [IP_W-1:0] zext_target(input logic [TARGET_W-1:0] target);
        return {{(IP_W - TARGET_W){1'b0}}, target};
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO for pc_sequencer: synchronous push/pop with full/empty status.
// Only the stack pointer is reset; the entries keep whatever they last held.
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = IP_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] SP_FULL = (AW + 1)'(DEPTH);

    logic [AW:0]      r_sp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_top_idx;

    assign o_full    = (r_sp == SP_FULL);
    assign o_empty   = (r_sp == '0);
    assign w_top_idx = AW'(r_sp - SP_ONE);
    assign o_top     = r_mem[w_top_idx];

    // NOTE: sequential state is updated with non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sp <= '0;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_ONE;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_ONE;
        end
    end

    // NOTE: the entry array is deliberately left out of reset; an empty pointer already makes it unreadable.
    always_ff @(posedge Clock) begin
        if (i_push && !i_pop && !o_full) begin
            r_mem[r_sp[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-pointer stage feeding the program ROM: step, JMP/branch, CALL/RET with a hardware
// return stack and sticky overflow/underflow flags. Define PC_NOP_WAIT_EN to enable the NOP wait state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               STACK_DEPTH  = 8,
    parameter logic [IP_W-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStall,
    input  logic                 iJump,
    input  logic                 iBranchTaken,
    input  logic                 iCall,
    input  logic                 iRet,
    input  logic [TARGET_W-1:0]  iTarget,
    input  logic                 iNop,
    input  logic [NOP_CNT_W-1:0] iNopCount,
    output logic [IP_W-1:0]      oIP,
    output logic                 oStackOverflow,
    output logic                 oStackUnderflow,
    output logic                 oBusy
);

    state_e          r_state;
    state_e          w_next_state;
    logic [IP_W-1:0] r_ip;
    logic [IP_W-1:0] w_next_ip;
    logic [IP_W-1:0] w_ip_inc;
    logic [IP_W-1:0] w_target;
    logic [IP_W-1:0] w_stack_top;
    logic            r_ovf;
    logic            r_unf;
    logic            w_set_ovf;
    logic            w_set_unf;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

`ifdef PC_NOP_WAIT_EN
    localparam logic [NOP_CNT_W-1:0] NOP_ONE = NOP_CNT_W'(1);
    logic [NOP_CNT_W-1:0] r_nop_cnt;
    logic [NOP_CNT_W-1:0] w_next_nop_cnt;
`else
    logic w_unused_nop;
    assign w_unused_nop = ^{iNop, iNopCount};
`endif

    assign w_ip_inc = r_ip + 16'd1;
    assign w_target = zext_target(iTarget);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (IP_W)
    ) u_return_stack (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ip_inc),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: every combinational output gets a default first, so no path can leave one unassigned (no latches).
    always_comb begin
        w_next_ip    = r_ip;
        w_next_state = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
`ifdef PC_NOP_WAIT_EN
        w_next_nop_cnt = r_nop_cnt;
`endif
        if (!iStall) begin
            case (r_state)
                STATE_RUN: begin
                    if (iRet) begin
                        if (w_empty) begin
                            w_next_ip = RESET_VECTOR;
                            w_set_unf = 1'b1;
                        end else begin
                            w_next_ip = w_stack_top;
                            w_pop     = 1'b1;
                        end
                    end else if (iCall) begin
                        // A full stack drops the return address but the jump still happens.
                        w_next_ip = w_target;
                        if (w_full) begin
                            w_set_ovf = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else if (iJump || iBranchTaken) begin
                        w_next_ip = w_target;
`ifdef PC_NOP_WAIT_EN
                    end else if (iNop && (iNopCount != '0)) begin
                        w_next_state   = STATE_WAIT;
                        w_next_nop_cnt = iNopCount;
`endif
                    end else begin
                        w_next_ip = w_ip_inc;
                    end
                end
`ifdef PC_NOP_WAIT_EN
                STATE_WAIT: begin
                    // The counter holds the remaining wait cycles; the last one also steps the IP.
                    if (r_nop_cnt <= NOP_ONE) begin
                        w_next_state   = STATE_RUN;
                        w_next_nop_cnt = '0;
                        w_next_ip      = w_ip_inc;
                    end else begin
                        w_next_nop_cnt = r_nop_cnt - NOP_ONE;
                    end
                end
`endif
                default: begin
                    w_next_state = STATE_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ip    <= RESET_VECTOR;
            r_state <= STATE_RUN;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
`ifdef PC_NOP_WAIT_EN
            r_nop_cnt <= '0;
`endif
        end else begin
            r_ip    <= w_next_ip;
            r_state <= w_next_state;
            r_ovf   <= r_ovf | w_set_ovf;
            r_unf   <= r_unf | w_set_unf;
`ifdef PC_NOP_WAIT_EN
            r_nop_cnt <= w_next_nop_cnt;
`endif
        end
    end

    assign oIP             = r_ip;
    assign oStackOverflow  = r_ovf;
    assign oStackUnderflow = r_unf;
`ifdef PC_NOP_WAIT_EN
    assign oBusy = (r_state == STATE_WAIT);
`else
    assign oBusy = 1'b0;
`endif

endmodule
